// File: rtl/adder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder_pkg
//   Shared constants for the registered 32-bit ripple adder.
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
package adder_pkg;

  // Datapath width of the adder; ports are numbered [ADDER_WIDTH:1].
  localparam int ADDER_WIDTH = 32;

  // Value loaded into the sum register while rst is high.
  localparam logic [ADDER_WIDTH-1:0] ADDER_RST_VAL = 32'h0000_0000;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// full_adder
//   One-bit combinational full adder; one cell of the ripple carry chain.
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum is the three-input parity; carry is the three-input majority.
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder
`default_nettype wire

// File: rtl/adder_32bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder_32bit
//   Registered 32-bit adder, y = a + b mod 2^32, one cycle latency.
//   The carry chain is an explicit ripple of full_adder cells so the
//   gate-level structure stays visible after synthesis.
//   Optional feature macro: ADDER_32BIT_FLAGS_EN adds registered carry-out
//   (cout) and signed overflow (ovf) outputs.
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module adder_32bit
  import adder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDER_WIDTH:1]   a,
  input  logic [ADDER_WIDTH:1]   b,
  output logic [ADDER_WIDTH:1]   y
`ifdef ADDER_32BIT_FLAGS_EN
  ,
  output logic                   cout,
  output logic                   ovf
`endif
);

  // Carry vector: c[0] is the forced-zero carry-in, c[i] is the carry out
  // of bit i, so c[ADDER_WIDTH] is the carry out of the MSB.
  logic [ADDER_WIDTH:0] c;
  logic [ADDER_WIDTH:1] s;

  // Sum register and its next-state value.
  logic [ADDER_WIDTH:1] y_d;
  logic [ADDER_WIDTH:1] y_q;

  assign c[0] = 1'b0;

  // Ripple chain: bit i consumes the carry from bit i-1.
  generate
    for (genvar i = 1; i <= ADDER_WIDTH; i++) begin : g_ripple
      full_adder u_fa (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (c[i-1]),
        .sum  (s[i]),
        .cout (c[i])
      );
    end
  endgenerate

  // Next sum is the raw ripple result; the MSB carry never enters y.
  always_comb begin
    y_d = s;
  end

  // Sum register with synchronous reset taking priority over the new sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= ADDER_RST_VAL;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

`ifdef ADDER_32BIT_FLAGS_EN
  // Flag next-state values. Signed overflow occurs exactly when the carry
  // into the sign bit differs from the carry out of it.
  logic cout_d;
  logic cout_q;
  logic ovf_d;
  logic ovf_q;

  // Derive flags from the top two carries of the ripple chain.
  always_comb begin
    cout_d = c[ADDER_WIDTH];
    ovf_d  = c[ADDER_WIDTH] ^ c[ADDER_WIDTH-1];
  end

  // Flag registers share the reset behaviour of the sum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cout = cout_q;
  assign ovf  = ovf_q;
`else
  // Without flags the MSB carry has no consumer; tie it off explicitly.
  logic unused_carry_msb;
  assign unused_carry_msb = c[ADDER_WIDTH];
`endif

endmodule : adder_32bit
`default_nettype wire

// File: tb/tb_adder_32bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adder_32bit
//   Self-checking bench for adder_32bit: directed vectors with hand-computed
//   results, then a random run with a one-cycle reset pulse in the middle.
//   Flag checks are compiled in when ADDER_32BIT_FLAGS_EN is defined.
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_adder_32bit;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;
`ifdef ADDER_32BIT_FLAGS_EN
  logic        cout;
  logic        ovf;
`endif

  int n_checks;
  int n_fail;

  adder_32bit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .y    (y)
`ifdef ADDER_32BIT_FLAGS_EN
    ,
    .cout (cout),
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all outputs against expected sum and flags.
  task automatic check_all(input string tag, input logic [31:0] ey, input logic ec, input logic ev);
    check({tag, ".y"}, y, ey);
`ifdef ADDER_32BIT_FLAGS_EN
    check({tag, ".cout"}, {31'b0, cout}, {31'b0, ec});
    check({tag, ".ovf"},  {31'b0, ovf},  {31'b0, ev});
`else
    if (ec === 1'bx || ev === 1'bx) check({tag, ".flagx"}, 32'h1, 32'h0);
`endif
  endtask

  // Advance one rising edge and move to a point safely after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Safety net in case the clock stops or the sequence stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] ref_sum;
    logic        exp_c;
    logic        exp_v;
    logic        rst_now;

    n_checks = 0;
    n_fail   = 0;

    // Reset held for two edges with live operands present.
    rst = 1'b1;
    a   = 32'hFFFF_FFFB;
    b   = 32'h0000_0003;
    tick();
    check_all("reset_edge1", 32'h0, 1'b0, 1'b0);
    tick();
    check_all("reset_edge2", 32'h0, 1'b0, 1'b0);

    // -5 + 3 = -2; first valid sum one edge after reset release.
    rst = 1'b0;
    tick();
    check_all("neg_plus_pos", 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Unsigned wrap.
    a = 32'hFFFF_FFFF; b = 32'h0000_0001;
    tick();
    check_all("unsigned_wrap", 32'h0000_0000, 1'b1, 1'b0);

    // Positive signed overflow.
    a = 32'h7FFF_FFFF; b = 32'h0000_0001;
    tick();
    check_all("pos_overflow", 32'h8000_0000, 1'b0, 1'b1);

    // Negative signed overflow with carry out.
    a = 32'h8000_0000; b = 32'h8000_0000;
    tick();
    check_all("neg_overflow", 32'h0000_0000, 1'b1, 1'b1);

    // Full-length ripple, then an immediate change to verify exact latency.
    a = 32'h5555_5555; b = 32'hAAAA_AAAB;
    tick();
    check_all("full_ripple", 32'h0000_0000, 1'b1, 1'b0);
    a = 32'h1234_5678; b = 32'h0000_0000;
    tick();
    check_all("b2b_pass", 32'h1234_5678, 1'b0, 1'b0);

    // Random pairs with a single reset pulse in the middle.
    for (int i = 0; i < 1000; i++) begin
      rst_now = (i == 500);
      rst = rst_now;
      a   = $urandom;
      b   = $urandom;
      ref_sum = {1'b0, a} + {1'b0, b};
      exp_c   = ref_sum[32];
      exp_v   = (a[31] == b[31]) && (ref_sum[31] != a[31]);
      tick();
      if (rst_now) begin
        check_all("rand_mid_reset", 32'h0, 1'b0, 1'b0);
      end else begin
        check_all("rand_sum", ref_sum[31:0], exp_c, exp_v);
      end
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adder_32bit
`default_nettype wire

// File: doc/adder_32bit.md
# adder_32bit

Registered 32-bit two's-complement/unsigned adder for the ALU datapath: y = a + b modulo 2^32, captured on the rising clock edge. It is the add primitive that the ALU wrapper muxes with its other operations. The carry chain is an explicit ripple of 32 one-bit full adders, with no inferred `+` operator, so that the gate-level structure can be inspected.

## Interface
- Parameters: none. Width is fixed at 32 via the shared package constant ADDER_WIDTH = 32.
- Reset: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  [32:1]  operand A. Bit 1 is the LSB, bit 32 the MSB/sign.
- b  input  [32:1]  operand B, same numbering.
- y  output  [32:1]  registered sum a + b, low 32 bits.
- cout  output  1  registered carry out of bit 32. Present only with ADDER_32BIT_FLAGS_EN.
- ovf  output  1  registered signed overflow. Present only with ADDER_32BIT_FLAGS_EN.

## Operation
- Combinational ripple: c[0] = 0; for i = 1..32, s[i] = a[i] ^ b[i] ^ c[i-1] and c[i] = majority(a[i], b[i], c[i-1]).
- Sum register: y <= s[32:1] each clock when rst = 0.
- Wrap-around: the result is modulo 2^32. The carry is discarded from y.
- Signedness: the same bits serve signed and unsigned interpretation, with no sign extension.
- Flags (macro on):
  - cout <= c[32].
  - ovf <= (a[32] == b[32]) && (s[32] != a[32]), which equals c[32] ^ c[31].
- No handshake: inputs are sampled every cycle and there is no valid/ready.
- X on inputs propagates to outputs. There is no masking.

## Timing
- Latency is 1 cycle: inputs present before edge N appear on y after edge N.
- Throughput is one new operation per cycle.
- Reset values: y = 32'h0, cout = 0, ovf = 0.
- Reset has priority over the sum. When rst = 1 at an edge, all outputs become 0 regardless of a/b.
- Reset mid-stream: the in-flight result is lost. The first valid sum appears one edge after rst deasserts, using the inputs sampled at that edge.
- Combinational path: the worst case is the full 32-bit ripple (a[1]/b[1] to s[32]), which must close within one clk period.

## Configuration
- ADDER_32BIT_FLAGS_EN defined: the cout and ovf ports and their registers exist as specified above.
- ADDER_32BIT_FLAGS_EN undefined: the cout and ovf ports are absent. c[32] is left unused, and y is identical in both builds.

## Structure
- Shared package `adder_pkg`: ADDER_WIDTH = 32, and the reset value constant ADDER_RST_VAL = 32'h0.
- Sub-module `full_adder` (ports a, b, cin, sum, cout, purely combinational) is instantiated 32 times via generate to form the ripple chain.
- The top-level holds the carry vector c[32:0], the output registers and the macro-guarded flag logic.

## Test plan
- Reset: hold rst = 1 with a = 32'hFFFFFFFB, b = 32'h3 for 2 edges -> y = 0, cout = 0, ovf = 0.
- Negative plus positive: a = 32'hFFFFFFFB (-5), b = 32'h00000003 -> y = 32'hFFFFFFFE (-2) one edge later, cout = 0, ovf = 0.
- Unsigned wrap: a = 32'hFFFFFFFF, b = 32'h00000001 -> y = 32'h00000000, cout = 1, ovf = 0.
- Signed overflow: a = 32'h7FFFFFFF, b = 32'h00000001 -> y = 32'h80000000, cout = 0, ovf = 1. Also a = b = 32'h80000000 -> y = 0, cout = 1, ovf = 1.
- Back-to-back and full ripple:
  - Change the inputs every cycle, with pairs (32'h55555555, 32'hAAAAAAAB) -> y = 0 and cout = 1, then (32'h12345678, 32'h0) -> y = 32'h12345678.
  - Each result must appear exactly one edge after its inputs.
- Random plus reset mid-stream: 1000 random pairs compared against a reference a + b, with rst pulsed for one cycle mid-run -> y = 0 on that edge, and correct sums resume on the next edge.
